regfile_access_ctrl: RTL

- Initiator-side controller for the CPU register file.
- Accepts operand-read requests from decode and writeback requests from the execute/memory stage, each on its own valid/ready handshake.
- Sequences both onto the register file's single shared access slot. The register file performs either one write or one read per cycle, with the write taking precedence, and read data appears on its dout ports one cycle after the read enable.
- Returns captured operands on a valid/ready response channel.

---
 rtl/regfile_access_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/regfile_access_ctrl.sv
// Register file access controller: serialises operand reads and writebacks onto the
// single shared register-file slot, with a burst limit so writes cannot starve reads.
module regfile_access_ctrl #(
   parameter int reg_width    = 5,
   parameter int data_width   = 32,
   parameter int max_wb_burst = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rd_req_valid,
   output logic                  rd_req_ready,
   input  logic [reg_width-1:0]  rd_req_rs1,
   input  logic [reg_width-1:0]  rd_req_rs2,
   input  logic                  rd_req_use_rs2,
   output logic                  rd_resp_valid,
   input  logic                  rd_resp_ready,
   output logic [data_width-1:0] rd_resp_rs1_data,
   output logic [data_width-1:0] rd_resp_rs2_data,
   input  logic                  wb_valid,
   output logic                  wb_ready,
   input  logic [reg_width-1:0]  wb_rd,
   input  logic [data_width-1:0] wb_data,
   output logic                  rf_rd_en,
   output logic [reg_width-1:0]  rf_rd,
   output logic [data_width-1:0] rf_rd_din,
   output logic                  rf_rs1_en,
   output logic                  rf_rs2_en,
   output logic [reg_width-1:0]  rf_rs1,
   output logic [reg_width-1:0]  rf_rs2,
   input  logic [data_width-1:0] rf_rs1_dout,
   input  logic [data_width-1:0] rf_rs2_dout
);

   localparam int CNT_W = $clog2(max_wb_burst + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      READ_WAIT = 2'd1,
      RESP      = 2'd2
   } state_t;

   state_t                  state_q;
   logic [CNT_W-1:0]        cnt_q;
   logic [CNT_W-1:0]        cnt_d;
   logic [reg_width-1:0]    rs1_q;
   logic [reg_width-1:0]    rs2_q;
   logic                    use_rs2_q;
   logic [data_width-1:0]   resp_rs1_q;
   logic [data_width-1:0]   resp_rs2_q;

   logic                    idle_s;
   logic                    force_rd_s;
   logic                    wb_grant_s;
   logic                    rd_issue_s;

   // Slot arbitration: writes win unless the burst limit forces a pending read through.
   always_comb begin
      idle_s       = (state_q == IDLE);
      force_rd_s   = rst && idle_s && rd_req_valid && (cnt_q == CNT_W'(max_wb_burst));
      wb_ready     = rst && !force_rd_s;
      wb_grant_s   = wb_valid && wb_ready;
      rd_req_ready = rst && idle_s && !wb_grant_s;
      rd_issue_s   = rd_req_valid && rd_req_ready;

      rf_rd_en  = wb_grant_s && (wb_rd != '0);
      rf_rd     = wb_grant_s ? wb_rd : '0;
      rf_rd_din = wb_grant_s ? wb_data : '0;
      rf_rs1_en = rd_issue_s;
      rf_rs2_en = rd_issue_s && rd_req_use_rs2;
      rf_rs1    = rd_issue_s ? rd_req_rs1 : '0;
      rf_rs2    = rd_issue_s ? rd_req_rs2 : '0;

      if (!idle_s) begin
         cnt_d = cnt_q;
      end else if (rd_issue_s || !rd_req_valid) begin
         cnt_d = '0;
      end else if (wb_grant_s) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else begin
         cnt_d = cnt_q;
      end
   end

   assign rd_resp_valid    = (state_q == RESP);
   assign rd_resp_rs1_data = resp_rs1_q;
   assign rd_resp_rs2_data = resp_rs2_q;

   // Read sequencing FSM; x0 and unused rs2 are zeroed as the operands are captured.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         use_rs2_q  <= 1'b0;
         resp_rs1_q <= '0;
         resp_rs2_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         case (state_q)
            IDLE: begin
               if (rd_issue_s) begin
                  rs1_q     <= rd_req_rs1;
                  rs2_q     <= rd_req_rs2;
                  use_rs2_q <= rd_req_use_rs2;
                  state_q   <= READ_WAIT;
               end else begin
                  state_q   <= IDLE;
               end
            end
            READ_WAIT: begin
               resp_rs1_q <= (rs1_q == '0) ? '0 : rf_rs1_dout;
               resp_rs2_q <= (use_rs2_q && (rs2_q != '0)) ? rf_rs2_dout : '0;
               state_q    <= RESP;
            end
            RESP: begin
               if (rd_resp_ready) begin
                  state_q <= IDLE;
               end else begin
                  state_q <= RESP;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule
